// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-stage load/store engine for the RISC-V core. Accepts one load or
// store per request, drives a held read/write handshake toward data memory
// with lane byte enables, and aligns and extends returned load data for the
// writeback select multiplexer. Misaligned or illegal requests never reach
// memory; they complete through a one-cycle error response.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            request strobe, only looked at while idle
//   is_store         1 = store, 0 = load
//   funct3           RV32I width/sign code
//   addr             byte address
//   store_data       rs2 value (low bits used for SB/SH)
//   mem_resp         one-cycle memory completion pulse
//   mem_rdata        read word, valid with mem_resp
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp
//   mem_address      word-aligned address
//   mem_byte_enable  write lane enables, all ones for reads
//   mem_wdata        lane-replicated store data
//   busy             unit is not idle
//   done             one-cycle completion pulse
//   err              qualifies done: request was misaligned or illegal
//   load_data        aligned and extended result of the last completed load

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        FAULT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] load_q;

    logic        legal;
    logic        misaligned;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic [31:0] shifted;
    logic [31:0] extracted;

    // Classify the incoming request. Only funct3[1:0] matters for alignment;
    // codes with funct3[1:0] == 11 are rejected by the legality check anyway.
    always_comb begin
        legal = 1'b0;
        if (is_store) begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Replicate store data across every lane so the byte enables alone pick
    // which bytes land in memory. Reads always fetch the whole word.
    always_comb begin
        fmt_wdata = store_data;
        fmt_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                fmt_wdata = {4{store_data[7:0]}};
                fmt_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{store_data[15:0]}};
                fmt_be    = 4'b0011 << addr[1:0];
            end
            default: begin
                fmt_wdata = store_data;
                fmt_be    = 4'b1111;
            end
        endcase
        if (!is_store) begin
            fmt_be = 4'b1111;
        end
    end

    // Shift the addressed byte/halfword down to bit 0, then extend it.
    always_comb begin
        shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
        extracted = shifted;
        case (funct3_q)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  extracted = {24'h000000, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  extracted = {16'h0000, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. The request lines come only from
    // registered state so they drop the instant reset is asserted.
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (!legal || misaligned) ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                mem_read  = !is_store_q;
                mem_write = is_store_q;
                if (mem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture while idle, and load result capture on completion.
    // A store or a faulted request leaves load_q untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            wdata_q    <= 32'h0;
            be_q       <= 4'b0000;
            load_q     <= 32'h0;
        end else begin
            if ((state == IDLE) && start) begin
                addr_q     <= addr;
                funct3_q   <= funct3;
                is_store_q <= is_store;
                wdata_q    <= fmt_wdata;
                be_q       <= fmt_be;
            end
            if ((state == ACCESS) && mem_resp && !is_store_q) begin
                load_q <= extracted;
            end
        end
    end

    assign mem_address     = {addr_q[31:2], 2'b00};
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;
    assign load_data       = load_q;

endmodule
